// File: rtl/pkt_delay_line.sv
// Purpose: fixed-advance packet delay line; every accepted beat re-emerges D_act advances later.
// Latency: one cycle after the advance that reads the beat back (advance-counted, not cycle-counted).
// Backpressure: none; every valid beat is taken, and idle periods are drained by forced/idle-timeout bubbles.
module pkt_delay_line #(
   parameter int DATA_W  = 64,
   parameter int EMPTY_W = 3,
   parameter int ADDR_W  = 10,
   parameter int IDLE_W  = 24
) (
   input  logic               sys_clk,
   input  logic               reset_n,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_sop,
   input  logic               in_eop,
   input  logic [EMPTY_W-1:0] in_empty,
   input  logic               in_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_sop,
   output logic               out_eop,
   output logic [EMPTY_W-1:0] out_empty,
   output logic               out_valid,
   input  logic [ADDR_W-1:0]  cfg_delay,
   input  logic               cfg_load,
   input  logic               flush_force,
   input  logic               flush_inhibit,
   output logic               primed,
   output logic               auto_flush
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
      logic               valid;
   } entry_t;

   // Delay storage; contents are never reset, stale entries are masked by priming.
   entry_t              r_mem [DEPTH];

   logic [ADDR_W-1:0]   r_wptr;
   logic [ADDR_W-1:0]   r_dact;
   logic [ADDR_W-1:0]   r_prime_cnt;
   logic [IDLE_W-1:0]   r_idle_cnt;
   entry_t              r_out;

   logic                w_flush;
   logic                w_adv;
   logic                w_primed;
   logic                w_auto_flush;
   logic [ADDR_W-1:0]   w_dact_nxt;
   logic [ADDR_W-1:0]   w_dact_sel;
   logic [ADDR_W-1:0]   w_rptr;
   entry_t              w_wr_entry;
   entry_t              w_rd_entry;
   entry_t              w_out_nxt;

   // A flush only advances when not inhibited; a real beat always advances.
   assign w_auto_flush = &r_idle_cnt;
   assign w_flush      = (flush_force | w_auto_flush) & ~flush_inhibit;
   assign w_adv        = in_valid | w_flush;
   assign w_primed     = (r_prime_cnt == r_dact);

   // Resolve delay, read address, write entry and next output word for this cycle.
   always_comb begin
      // A zero delay would make read and write collide, so it is promoted to 1.
      w_dact_nxt = (cfg_delay == '0) ? ADDR_W'(1) : cfg_delay;
      // A load takes effect on the read address of the same cycle.
      w_dact_sel = cfg_load ? w_dact_nxt : r_dact;
      w_rptr     = r_wptr - w_dact_sel;
      w_rd_entry = r_mem[w_rptr];

      // Flush-only advances store an all-zero bubble.
      w_wr_entry = '0;
      if (in_valid) begin
         w_wr_entry.data  = in_data;
         w_wr_entry.sop   = in_sop;
         w_wr_entry.eop   = in_eop;
         w_wr_entry.empty = in_empty;
         w_wr_entry.valid = 1'b1;
      end

      // Emit only real beats read after priming completed; a load blanks its own advance.
      w_out_nxt = '0;
      if (w_adv && !cfg_load && w_primed && w_rd_entry.valid) begin
         w_out_nxt = w_rd_entry;
      end
   end

   // Store one entry per advance.
   always_ff @(posedge sys_clk) begin
      if (w_adv) begin
         r_mem[r_wptr] <= w_wr_entry;
      end
   end

   // Write pointer, active delay and priming counter.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr      <= '0;
         r_dact      <= ADDR_W'(1);
         r_prime_cnt <= '0;
      end else begin
         if (w_adv) begin
            r_wptr <= r_wptr + ADDR_W'(1);
         end
         if (cfg_load) begin
            r_dact      <= w_dact_nxt;
            r_prime_cnt <= w_adv ? ADDR_W'(1) : '0;
         end else if (w_adv && !w_primed) begin
            r_prime_cnt <= r_prime_cnt + ADDR_W'(1);
         end
      end
   end

   // Idle timeout counter; keeps counting under inhibit so release flushes at once.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idle_cnt <= '0;
      end else if (in_valid) begin
         r_idle_cnt <= '0;
      end else if (!w_auto_flush) begin
         r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end
   end

   // Output register; zero whenever no beat is presented.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out <= '0;
      end else begin
         r_out <= w_out_nxt;
      end
   end

   assign out_data   = r_out.data;
   assign out_sop    = r_out.sop;
   assign out_eop    = r_out.eop;
   assign out_empty  = r_out.empty;
   assign out_valid  = r_out.valid;
   assign primed     = w_primed;
   assign auto_flush = w_auto_flush;

endmodule

// File: tb/tb_pkt_delay_line.sv
// Purpose: directed checks of pkt_delay_line with small geometry (8 entries, 4-bit idle timer).
// Latency: outputs are compared at the falling edge after each consuming rising edge.
// Backpressure: not applicable; stimulus is a fixed table plus hand sequences.
module tb_pkt_delay_line;

   logic        sys_clk;
   logic        reset_n;
   logic [15:0] in_data;
   logic        in_sop;
   logic        in_eop;
   logic [2:0]  in_empty;
   logic        in_valid;
   logic [15:0] out_data;
   logic        out_sop;
   logic        out_eop;
   logic [2:0]  out_empty;
   logic        out_valid;
   logic [2:0]  cfg_delay;
   logic        cfg_load;
   logic        flush_force;
   logic        flush_inhibit;
   logic        primed;
   logic        auto_flush;

   int n_cmp = 0;
   int n_bad = 0;

   pkt_delay_line #(
      .DATA_W  (16),
      .EMPTY_W (3),
      .ADDR_W  (3),
      .IDLE_W  (4)
   ) dut (
      .sys_clk       (sys_clk),
      .reset_n       (reset_n),
      .in_data       (in_data),
      .in_sop        (in_sop),
      .in_eop        (in_eop),
      .in_empty      (in_empty),
      .in_valid      (in_valid),
      .out_data      (out_data),
      .out_sop       (out_sop),
      .out_eop       (out_eop),
      .out_empty     (out_empty),
      .out_valid     (out_valid),
      .cfg_delay     (cfg_delay),
      .cfg_load      (cfg_load),
      .flush_force   (flush_force),
      .flush_inhibit (flush_inhibit),
      .primed        (primed),
      .auto_flush    (auto_flush)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   typedef struct packed {
      logic        rst;
      logic        vld;
      logic        sop;
      logic        eop;
      logic [2:0]  emp;
      logic [15:0] dat;
      logic        load;
      logic [2:0]  dly;
      logic        frc;
      logic        inh;
      logic        e_vld;
      logic [15:0] e_dat;
      logic        e_sop;
      logic        e_eop;
      logic [2:0]  e_emp;
      logic        e_pri;
      logic        e_af;
   } row_t;

   row_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic e_vld, input logic [15:0] e_dat,
                            input logic e_sop, input logic e_eop, input logic [2:0] e_emp,
                            input logic e_pri, input logic e_af);
      chk({tag, "/valid"}, 32'(out_valid), 32'(e_vld));
      chk({tag, "/data"},  32'(out_data),  32'(e_dat));
      chk({tag, "/sop"},   32'(out_sop),   32'(e_sop));
      chk({tag, "/eop"},   32'(out_eop),   32'(e_eop));
      chk({tag, "/empty"}, 32'(out_empty), 32'(e_emp));
      chk({tag, "/primed"}, 32'(primed),   32'(e_pri));
      chk({tag, "/auto_flush"}, 32'(auto_flush), 32'(e_af));
   endtask

   task automatic drive(input logic vld, input logic sop, input logic eop, input logic [2:0] emp,
                        input logic [15:0] dat, input logic load, input logic [2:0] dly,
                        input logic frc, input logic inh);
      in_valid      = vld;
      in_sop        = sop;
      in_eop        = eop;
      in_empty      = emp;
      in_data       = dat;
      cfg_load      = load;
      cfg_delay     = dly;
      flush_force   = frc;
      flush_inhibit = inh;
   endtask

   task automatic tick();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   task automatic step_beat(input logic [15:0] dat, input logic load, input logic [2:0] dly,
                            input logic inh);
      drive(1'b1, 1'b0, 1'b0, 3'd0, dat, load, dly, 1'b0, inh);
      tick();
   endtask

   task automatic step_idle(input logic load, input logic [2:0] dly, input logic frc,
                            input logic inh);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, load, dly, frc, inh);
      tick();
   endtask

   // Asynchronous reset: outputs must clear without a clock edge.
   task automatic do_reset(input string tag);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      check_out(tag, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge sys_clk);
      reset_n = 1'b1;
   endtask

   initial begin
      row_t r;
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);

      // Stream of 10 beats at D=4.
      r = '0; r.rst = 1'b1; tbl.push_back(r);
      r = '0; r.load = 1'b1; r.dly = 3'd4; tbl.push_back(r);
      for (int k = 1; k <= 10; k++) begin
         r = '0;
         r.vld = 1'b1; r.dat = 16'(k); r.sop = (k == 1); r.eop = (k == 6); r.emp = 3'(k);
         if (k >= 5) begin
            r.e_vld = 1'b1; r.e_dat = 16'(k - 4);
            r.e_sop = (k == 5); r.e_eop = (k == 10); r.e_emp = 3'(k - 4);
         end
         r.e_pri = (k >= 4);
         tbl.push_back(r);
      end
      r = '0; r.e_pri = 1'b1; tbl.push_back(r);

      // Reset mid-stream, then 3 beats drained by flush_force at D=4.
      r = '0; r.rst = 1'b1; tbl.push_back(r);
      r = '0; r.load = 1'b1; r.dly = 3'd4; tbl.push_back(r);
      r = '0; r.vld = 1'b1; r.dat = 16'h11; r.sop = 1'b1; tbl.push_back(r);
      r = '0; r.vld = 1'b1; r.dat = 16'h12; tbl.push_back(r);
      r = '0; r.vld = 1'b1; r.dat = 16'h13; r.eop = 1'b1; r.emp = 3'd2; tbl.push_back(r);
      for (int j = 1; j <= 6; j++) begin
         r = '0; r.frc = 1'b1; r.e_pri = 1'b1;
         if (j == 2) begin r.e_vld = 1'b1; r.e_dat = 16'h11; r.e_sop = 1'b1; end
         if (j == 3) begin r.e_vld = 1'b1; r.e_dat = 16'h12; end
         if (j == 4) begin r.e_vld = 1'b1; r.e_dat = 16'h13; r.e_eop = 1'b1; r.e_emp = 3'd2; end
         tbl.push_back(r);
      end

      // cfg_delay=0 latches as 1; beat plus flush_force is a single advance.
      r = '0; r.rst = 1'b1; tbl.push_back(r);
      r = '0; r.vld = 1'b1; r.dat = 16'hA1; r.load = 1'b1; r.dly = 3'd0; r.e_pri = 1'b1;
      tbl.push_back(r);
      r = '0; r.vld = 1'b1; r.dat = 16'hA2; r.frc = 1'b1; r.e_vld = 1'b1; r.e_dat = 16'hA1;
      r.e_pri = 1'b1; tbl.push_back(r);
      r = '0; r.vld = 1'b1; r.dat = 16'hA3; r.e_vld = 1'b1; r.e_dat = 16'hA2; r.e_pri = 1'b1;
      tbl.push_back(r);
      r = '0; r.frc = 1'b1; r.e_vld = 1'b1; r.e_dat = 16'hA3; r.e_pri = 1'b1; tbl.push_back(r);
      r = '0; r.frc = 1'b1; r.e_pri = 1'b1; tbl.push_back(r);

      @(negedge sys_clk);

      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            do_reset($sformatf("row%0d_reset", i));
         end else begin
            drive(tbl[i].vld, tbl[i].sop, tbl[i].eop, tbl[i].emp, tbl[i].dat,
                  tbl[i].load, tbl[i].dly, tbl[i].frc, tbl[i].inh);
            tick();
            check_out($sformatf("row%0d", i), tbl[i].e_vld, tbl[i].e_dat, tbl[i].e_sop,
                      tbl[i].e_eop, tbl[i].e_emp, tbl[i].e_pri, tbl[i].e_af);
         end
      end

      // Idle timeout at D=2: auto_flush after 15 idle cycles drains the single beat.
      do_reset("af_reset");
      step_idle(1'b1, 3'd2, 1'b0, 1'b0);
      check_out("af_load", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      step_beat(16'h3AA, 1'b0, 3'd0, 1'b0);
      check_out("af_beat", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         step_idle(1'b0, 3'd0, 1'b0, 1'b0);
         check_out($sformatf("af_idle%0d", i), 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, (i == 15));
      end
      step_idle(1'b0, 3'd0, 1'b0, 1'b0);
      check_out("af_bubble", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      step_idle(1'b0, 3'd0, 1'b0, 1'b0);
      check_out("af_drain", 1'b1, 16'h3AA, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      step_beat(16'h3BB, 1'b0, 3'd0, 1'b0);
      check_out("af_clear", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

      // flush_inhibit holds the line through a timeout but never blocks real beats.
      do_reset("inh_reset");
      step_beat(16'h401, 1'b1, 3'd2, 1'b1);
      check_out("inh_b1", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      step_beat(16'h402, 1'b0, 3'd0, 1'b1);
      check_out("inh_b2", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         step_idle(1'b0, 3'd0, 1'b0, 1'b1);
         check_out($sformatf("inh_idle%0d", i), 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1, (i >= 15));
      end
      step_beat(16'h403, 1'b0, 3'd0, 1'b1);
      check_out("inh_b3", 1'b1, 16'h401, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         step_idle(1'b0, 3'd0, 1'b0, 1'b1);
         check_out($sformatf("inh_wait%0d", i), 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1, (i == 15));
      end
      step_idle(1'b0, 3'd0, 1'b0, 1'b0);
      check_out("inh_rel1", 1'b1, 16'h402, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      step_idle(1'b0, 3'd0, 1'b0, 1'b0);
      check_out("inh_rel2", 1'b1, 16'h403, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      step_idle(1'b0, 3'd0, 1'b0, 1'b0);
      check_out("inh_rel3", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

      // Maximum delay 7 on an 8-entry buffer; pointer wraps twice.
      do_reset("wrap_reset");
      step_idle(1'b1, 3'd7, 1'b0, 1'b0);
      check_out("wrap_load", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         step_beat(16'(32'h100 + k), 1'b0, 3'd0, 1'b0);
         check_out($sformatf("wrap%0d", k), (k >= 8), (k >= 8) ? 16'(32'h100 + k - 7) : 16'h0,
                   1'b0, 1'b0, 3'd0, (k >= 7), 1'b0);
      end

      // Delay change 5 -> 2 mid-stream, load coincident with a beat.
      do_reset("redly_reset");
      step_idle(1'b1, 3'd5, 1'b0, 1'b0);
      check_out("redly_load", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         step_beat(16'(32'h200 + k), 1'b0, 3'd0, 1'b0);
         check_out($sformatf("redly%0d", k), (k >= 6), (k >= 6) ? 16'(32'h200 + k - 5) : 16'h0,
                   1'b0, 1'b0, 3'd0, (k >= 5), 1'b0);
      end
      step_beat(16'h208, 1'b1, 3'd2, 1'b0);
      check_out("redly8", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      step_beat(16'h209, 1'b0, 3'd0, 1'b0);
      check_out("redly9", 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      step_beat(16'h20A, 1'b0, 3'd0, 1'b0);
      check_out("redly10", 1'b1, 16'h208, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      step_beat(16'h20B, 1'b0, 3'd0, 1'b0);
      check_out("redly11", 1'b1, 16'h209, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pkt_delay_line.md
PKT_DELAY_LINE -- requirements
Module: pkt_delay_line

Interface
REQ-001 Parameter DATA_W, default 64, Avalon-ST data width in bits.
REQ-002 Parameter EMPTY_W, default 3, empty field width in bits.
REQ-003 Parameter ADDR_W, default 10, buffer address width; depth = 2^ADDR_W entries.
REQ-004 Parameter IDLE_W, default 24, idle counter width; auto-flush after 2^IDLE_W-1 idle cycles.
REQ-005 sys_clk  in  1  clock; all state SHALL be updated on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 in_data/in_sop/in_eop/in_empty/in_valid  in  DATA_W/1/1/EMPTY_W/1  Avalon-ST sink; no ready, so every valid beat SHALL be accepted.
REQ-008 out_data/out_sop/out_eop/out_empty/out_valid  out  DATA_W/1/1/EMPTY_W/1  Avalon-ST source; no ready.
REQ-009 cfg_delay  in  ADDR_W  delay D in advances, sampled only on cfg_load.
REQ-010 cfg_load  in  1  single-cycle pulse; latches cfg_delay and restarts priming.
REQ-011 flush_force  in  1  forces an advance every cycle.
REQ-012 flush_inhibit  in  1  blocks all flush advances: forced and automatic.
REQ-013 primed  out  1  high once D advances have occurred since the last reset or cfg_load.
REQ-014 auto_flush  out  1  high while the idle timeout is driving flush advances.

Function
REQ-015 Buffer entry = {data, sop, eop, empty, valid}; the memory SHALL have 2^ADDR_W entries with one write and one read per advance.
REQ-016 flush = (flush_force | auto_flush) & ~flush_inhibit; advance = in_valid | flush.
REQ-017 On advance: write the entry at wptr (valid bit = in_valid; a flush-only advance writes a bubble with valid=0 and all other fields 0); read the entry at rptr = wptr - D_act (mod 2^ADDR_W); wptr <= wptr+1 with natural wrap.
REQ-018 Latency: a beat accepted at advance n SHALL appear on the outputs in the cycle after advance n+D_act; it is not tied to wall-clock cycles.
REQ-019 D_act: latched from cfg_delay on cfg_load; cfg_delay=0 SHALL latch as 1; D_act is reset to 1; the maximum is 2^ADDR_W-1, so rptr never equals wptr.
REQ-020 prime_cnt (ADDR_W bits): counts advances since reset or cfg_load and saturates at D_act; primed = (prime_cnt == D_act).
REQ-021 out_valid SHALL be registered high in the cycle after an advance only if the read entry's valid bit = 1 and primed was 1 before that advance; otherwise 0.
REQ-022 When out_valid=0, out_data, out_sop, out_eop and out_empty SHALL all be 0.
REQ-023 A cycle with no advance SHALL deassert out_valid the next cycle and leave the pointers unchanged.
REQ-024 idle_cnt (IDLE_W bits): cleared on in_valid; otherwise increments and saturates at all-ones; auto_flush = &idle_cnt; auto_flush stays high until the next in_valid.
REQ-025 flush_inhibit SHALL NOT stop idle_cnt from counting and SHALL NOT block in_valid advances.
REQ-026 cfg_load priority: the new D_act applies to that same cycle's read address; prime_cnt <= advance ? 1 : 0; out_valid for that cycle's advance SHALL be 0; wptr SHALL NOT be reset.
REQ-027 Simultaneous in_valid and flush SHALL produce exactly one advance, which writes the real beat.
REQ-028 Packet framing is not checked; sop/eop SHALL pass through unmodified with their beat.

Reset
REQ-029 Assertion of reset_n SHALL asynchronously clear: wptr, prime_cnt, idle_cnt and the output register to 0; primed, auto_flush and out_valid to 0; D_act to 1.
REQ-030 Memory contents are not reset; REQ-021 masking SHALL guarantee that no stale entry is emitted after reset.
REQ-031 Reset asserted mid-packet SHALL discard all buffered beats; no partial packet SHALL be emitted afterwards.

Verification
REQ-032 Scenario: reset, cfg_load with D=4, then 10 consecutive beats with data 1..10 -> out_valid first high in the cycle after the 5th advance with data=1; data 1..6 output in order; primed high after the 4th advance.
REQ-033 Scenario: D=4, 3 beats, then idle with flush_force=1 -> the 3 beats emerge on consecutive cycles after the 5th-7th advances; bubbles give out_valid=0 and all outputs 0.
REQ-034 Scenario: IDLE_W=4, D=2, 1 beat, then idle -> auto_flush rises after 15 idle cycles; the beat emerges within 2 cycles of that; in_valid clears auto_flush the next cycle.
REQ-035 Scenario: flush_inhibit=1 plus long idle -> no advance and out_valid stays 0; the next beat still advances; releasing inhibit flushes.
REQ-036 Scenario: ADDR_W=3, D=7, 20 beats -> wptr wraps; output sequence equals input delayed 7 advances with no corruption.
REQ-037 Scenario: cfg_load D=2 in the same cycle as a beat, during streaming at D=5 -> out_valid=0 for that advance and the next; the third advance outputs the beat written 2 advances earlier.
